// File: rtl/serial_arith_pkg.sv
// Shared state encoding and width constants for the bit-serial arithmetic examples.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int N_DEF = 4;

  // Smallest counter width that can still represent the value N.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CW_DEF = cnt_width(N_DEF);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic xy_diff_s;

  assign xy_diff_s = x ^ y;
  assign d         = xy_diff_s ^ bin;
  assign bout      = (~x & y) | (~xy_diff_s & bin);

endmodule

// File: rtl/serial_subtractor_4bits.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, start/done handshake.
// Optional signed-overflow output Ovf when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor_4bits
  import serial_arith_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic         Clk,
  input  logic         Rst_b,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic         Busy,
  output logic         Done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         Ovf
`endif
);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_r;
  logic [N-1:0]  ra_r;
  logic [N-1:0]  rb_r;
  logic          borrow_r;
  logic [CW-1:0] cnt_r;
  logic          d_s;
  logic          bnext_s;

  full_subtractor u_fs (
    .x    (ra_r[0]),
    .y    (rb_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bnext_s)
  );

  // Handshake FSM, operand shift registers, borrow flop and bit counter.
  always_ff @(posedge Clk) begin
    if (!Rst_b) begin
      state_r  <= IDLE;
      ra_r     <= {N{1'b0}};
      rb_r     <= {N{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      D        <= {N{1'b0}};
      Bout     <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      Ovf      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            ra_r     <= A;
            rb_r     <= B;
            borrow_r <= Bin;
            cnt_r    <= {CW{1'b0}};
            D        <= {N{1'b0}};
            Busy     <= 1'b1;
            state_r  <= SHIFT;
          end else begin
            Busy     <= 1'b0;
          end
        end
        SHIFT: begin
          ra_r     <= {1'b0, ra_r[N-1:1]};
          rb_r     <= {1'b0, rb_r[N-1:1]};
          D        <= {d_s, D[N-1:1]};
          borrow_r <= bnext_s;
          cnt_r    <= cnt_r + CNT_ONE;
          // The MSB stage is the last one: its borrow-out is the result borrow.
          if (cnt_r == CNT_LAST) begin
            Bout    <= bnext_s;
`ifdef SERIAL_SUB_OVF_EN
            Ovf     <= borrow_r ^ bnext_s;
`endif
            Done    <= 1'b1;
            state_r <= DONE;
          end else begin
            Done    <= 1'b0;
          end
        end
        DONE: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bits.sv
// Self-checking bench for serial_subtractor_4bits against an arithmetic reference model.
module tb_serial_subtractor_4bits;

  localparam int N = 4;

  logic         Clk;
  logic         Rst_b;
  logic         Start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic [N-1:0] D;
  logic         Bout;
  logic         Busy;
  logic         Done;
`ifdef SERIAL_SUB_OVF_EN
  logic         Ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor_4bits #(.N(N), .CW(3)) dut (
    .Clk   (Clk),
    .Rst_b (Rst_b),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .Busy  (Busy),
    .Done  (Done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [3:0] ref_d(input int a, input int b, input int bin);
    int diff;
    diff = a - b - bin;
    return diff[3:0];
  endfunction

  function automatic logic ref_bout(input int a, input int b, input int bin);
    return (a < b + bin);
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int bin);
    int sa, sb, sd;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    sd = sa - sb - bin;
    return (sd < -8) || (sd > 7);
  endfunction

  // One full operation: start pulse, then watch Busy/Done for a bounded window.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin, input string tag);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    @(negedge Clk);
    Start = 1'b1; A = a; B = b; Bin = bin;
    for (int cyc = 1; cyc <= N + 4; cyc++) begin
      @(negedge Clk);
      Start = 1'b0;
      A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        done_at = cyc;
        chk({tag, "_d"}, 8'(D), 8'(ref_d(a, b, bin)));
        chk({tag, "_bout"}, 8'(Bout), 8'(ref_bout(a, b, bin)));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 8'(Ovf), 8'(ref_ovf(a, b, bin)));
`endif
      end
    end
    chk({tag, "_done_count"}, 8'(done_cnt), 8'd1);
    chk({tag, "_done_cycle"}, 8'(done_at), 8'(N + 1));
    chk({tag, "_busy_cycles"}, 8'(busy_cnt), 8'(N + 1));
    chk({tag, "_d_hold"}, 8'(D), 8'(ref_d(a, b, bin)));
    chk({tag, "_bout_hold"}, 8'(Bout), 8'(ref_bout(a, b, bin)));
  endtask

  initial begin
    int done_cnt;
    logic [3:0] ra, rb;
    logic       rbin;

    Rst_b = 1'b0; Start = 1'b0; A = 4'h0; B = 4'h0; Bin = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_d", 8'(D), 8'h00);
    chk("rst_bout", 8'(Bout), 8'h00);
    chk("rst_busy", 8'(Busy), 8'h00);
    chk("rst_done", 8'(Done), 8'h00);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 8'(Ovf), 8'h00);
`endif
    Rst_b = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Done || Busy) done_cnt++;
    end
    chk("idle_quiet", 8'(done_cnt), 8'h00);
    chk("idle_d_hold", 8'(D), 8'h00);

    run_op(4'd9, 4'd5, 1'b0, "basic");
    run_op(4'd5, 4'd9, 1'b0, "neg");
    run_op(4'd0, 4'd0, 1'b1, "bin_only");
    run_op(4'd15, 4'd0, 1'b0, "max_minus_zero");
    run_op(4'd0, 4'd15, 1'b1, "min_minus_max");

    // A second Start while busy must be ignored.
    done_cnt = 0;
    @(negedge Clk);
    Start = 1'b1; A = 4'd3; B = 4'd1; Bin = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge Clk);
      Start = (cyc == 2);
      A = (cyc == 2) ? 4'd15 : 4'd0;
      B = (cyc == 2) ? 4'd15 : 4'd0;
      if (Done) begin
        done_cnt++;
        chk("busy_prot_d", 8'(D), 8'h02);
        chk("busy_prot_bout", 8'(Bout), 8'h00);
      end
    end
    Start = 1'b0;
    chk("busy_prot_done_count", 8'(done_cnt), 8'd1);

    // Reset during the second SHIFT cycle discards the operation.
    @(negedge Clk);
    Start = 1'b1; A = 4'd9; B = 4'd2; Bin = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Rst_b = 1'b0;
    @(negedge Clk);
    Rst_b = 1'b1;
    chk("midrst_busy", 8'(Busy), 8'h00);
    chk("midrst_d", 8'(D), 8'h00);
    chk("midrst_done", 8'(Done), 8'h00);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Done) done_cnt++;
    end
    chk("midrst_no_done", 8'(done_cnt), 8'h00);
    run_op(4'd8, 4'd8, 1'b0, "after_rst");

    run_op(4'b0111, 4'b1000, 1'b0, "ovf_pos");
    run_op(4'b0011, 4'b0001, 1'b0, "ovf_none");
    run_op(4'b1000, 4'b0001, 1'b0, "ovf_neg");

    for (int i = 0; i < 20; i++) begin
      ra   = 4'($urandom);
      rb   = 4'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
